// File: rtl/pipeline_hazard_ctrl_if.sv
// Handshake/control bundle between the 5-stage pipeline and its hazard sequencer.
// master = pipeline side (drives hazard sources), slave = sequencer (drives stalls/flushes).
interface pipeline_hazard_ctrl_if #(
    parameter int CNT_W = 32
);
    logic [4:0]       if_id_rs1;
    logic [4:0]       if_id_rs2;
    logic [4:0]       id_ex_rd;
    logic             id_ex_mem_read;
    logic             ex_branch_taken;
    logic             ex_mem_mem_read;
    logic             ex_mem_mem_write;
    logic             dmem_ready;
    logic             dmem_valid;
    logic             pc_stall;
    logic             pc_redirect;
    logic             if_id_stall;
    logic             if_id_flush;
    logic             id_ex_stall;
    logic             id_ex_flush;
    logic             ex_mem_stall;
    logic             ex_mem_flush;
    logic             mem_wb_flush;
    logic             mem_timeout_err;
    logic [CNT_W-1:0] stall_cycle_cnt;

    modport master (
        output if_id_rs1, if_id_rs2, id_ex_rd, id_ex_mem_read, ex_branch_taken,
               ex_mem_mem_read, ex_mem_mem_write, dmem_ready,
        input  dmem_valid, pc_stall, pc_redirect, if_id_stall, if_id_flush,
               id_ex_stall, id_ex_flush, ex_mem_stall, ex_mem_flush, mem_wb_flush,
               mem_timeout_err, stall_cycle_cnt
    );

    modport slave (
        input  if_id_rs1, if_id_rs2, id_ex_rd, id_ex_mem_read, ex_branch_taken,
               ex_mem_mem_read, ex_mem_mem_write, dmem_ready,
        output dmem_valid, pc_stall, pc_redirect, if_id_stall, if_id_flush,
               id_ex_stall, id_ex_flush, ex_mem_stall, ex_mem_flush, mem_wb_flush,
               mem_timeout_err, stall_cycle_cnt
    );
endinterface

// File: rtl/pipeline_hazard_ctrl.sv
// Stall/flush sequencer for the 5-stage RV32I pipeline: data-memory wait, EX redirect and
// load-use bubbles, with a memory-wait FSM, sticky timeout flag and stall-cycle counter.
module pipeline_hazard_ctrl #(
    parameter int MEM_TIMEOUT = 16,
    parameter int CNT_W       = 32
) (
    input  logic                 clk,
    input  logic                 reset,
    pipeline_hazard_ctrl_if.slave hif
);
    typedef enum logic {RUN, MEM_WAIT} state_e;

    localparam int              WC_W      = $clog2(MEM_TIMEOUT + 1);
    localparam logic [WC_W-1:0] TIMEOUT_V = WC_W'(MEM_TIMEOUT);

    state_e           state_q, state_d;
    logic [WC_W-1:0]  wait_cnt_q, wait_cnt_d;
    logic             timeout_err_q, timeout_err_d;
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;

    logic mem_op, mem_wait, load_use;
    logic dmem_valid, pc_stall, pc_redirect;
    logic if_id_stall, if_id_flush, id_ex_stall, id_ex_flush, ex_mem_stall, mem_wb_flush;

    assign mem_op   = hif.ex_mem_mem_read | hif.ex_mem_mem_write;
    assign mem_wait = mem_op & ~hif.dmem_ready;
    assign load_use = hif.id_ex_mem_read && (hif.id_ex_rd != 5'd0) &&
                      ((hif.id_ex_rd == hif.if_id_rs1) || (hif.id_ex_rd == hif.if_id_rs2));

    // A taken branch seen while memory stalls stays parked in EX and redirects after release.
    always_comb begin
        dmem_valid   = 1'b0;
        pc_stall     = 1'b0;
        pc_redirect  = 1'b0;
        if_id_stall  = 1'b0;
        if_id_flush  = 1'b0;
        id_ex_stall  = 1'b0;
        id_ex_flush  = 1'b0;
        ex_mem_stall = 1'b0;
        mem_wb_flush = 1'b0;
        if (!reset) begin
            dmem_valid = mem_op;
            if (mem_wait) begin
                pc_stall     = 1'b1;
                if_id_stall  = 1'b1;
                id_ex_stall  = 1'b1;
                ex_mem_stall = 1'b1;
                mem_wb_flush = 1'b1;
            end else if (hif.ex_branch_taken) begin
                pc_redirect = 1'b1;
                if_id_flush = 1'b1;
                id_ex_flush = 1'b1;
            end else if (load_use) begin
                pc_stall    = 1'b1;
                if_id_stall = 1'b1;
                id_ex_flush = 1'b1;
            end
        end
    end

    always_comb begin
        state_d       = state_q;
        wait_cnt_d    = wait_cnt_q;
        timeout_err_d = timeout_err_q;
        stall_cnt_d   = stall_cnt_q + CNT_W'(pc_stall);
        case (state_q)
            RUN: begin
                if (mem_wait) begin
                    state_d    = MEM_WAIT;
                    wait_cnt_d = '0;
                end
            end
            MEM_WAIT: begin
                if (wait_cnt_q != TIMEOUT_V) wait_cnt_d = wait_cnt_q + WC_W'(1);
                if (wait_cnt_d == TIMEOUT_V) timeout_err_d = 1'b1;
                if (!mem_wait) state_d = RUN;
            end
            default: state_d = RUN;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q       <= RUN;
            wait_cnt_q    <= '0;
            timeout_err_q <= 1'b0;
            stall_cnt_q   <= '0;
        end else begin
            state_q       <= state_d;
            wait_cnt_q    <= wait_cnt_d;
            timeout_err_q <= timeout_err_d;
            stall_cnt_q   <= stall_cnt_d;
        end
    end

    assign hif.dmem_valid      = dmem_valid;
    assign hif.pc_stall        = pc_stall;
    assign hif.pc_redirect     = pc_redirect;
    assign hif.if_id_stall     = if_id_stall;
    assign hif.if_id_flush     = if_id_flush;
    assign hif.id_ex_stall     = id_ex_stall;
    assign hif.id_ex_flush     = id_ex_flush;
    assign hif.ex_mem_stall    = ex_mem_stall;
    assign hif.ex_mem_flush    = 1'b0;
    assign hif.mem_wb_flush    = mem_wb_flush;
    assign hif.mem_timeout_err = timeout_err_q;
    assign hif.stall_cycle_cnt = stall_cnt_q;
endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed bench for pipeline_hazard_ctrl: rule-level reference model checked every cycle,
// plus hand-computed literal expectations for the key scenarios.
module tb_pipeline_hazard_ctrl;
    localparam int T = 16;

    logic clk   = 1'b0;
    logic reset = 1'b1;
    int   checks = 0;
    int   passes = 0;

    always #5 clk = ~clk;

    pipeline_hazard_ctrl_if #(.CNT_W(32)) hif ();

    pipeline_hazard_ctrl #(.MEM_TIMEOUT(T), .CNT_W(32)) dut (
        .clk   (clk),
        .reset (reset),
        .hif   (hif)
    );

    // Reference state: cycles spent waiting on memory, error flag, stall total.
    logic        m_in_wait;
    int          m_wc;
    logic        m_err;
    logic [31:0] m_cnt;

    function automatic logic f_mem_wait();
        return (hif.ex_mem_mem_read | hif.ex_mem_mem_write) & ~hif.dmem_ready;
    endfunction

    function automatic logic f_load_use();
        return hif.id_ex_mem_read && hif.id_ex_rd != 0 &&
               (hif.id_ex_rd == hif.if_id_rs1 || hif.id_ex_rd == hif.if_id_rs2);
    endfunction

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m_in_wait = 1'b0;
            m_wc      = 0;
            m_err     = 1'b0;
            m_cnt     = 32'd0;
        end else begin
            logic mw;
            mw = f_mem_wait();
            if (m_in_wait) begin
                if (m_wc < T) m_wc = m_wc + 1;
                if (m_wc >= T) m_err = 1'b1;
            end else if (mw) begin
                m_wc = 0;
            end
            m_in_wait = mw;
            if (mw || (!hif.ex_branch_taken && f_load_use())) m_cnt = m_cnt + 32'd1;
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp)
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        else
            passes++;
    endtask

    always @(negedge clk) begin
        logic mw, br, lu, e_ps, e_red, e_ifs, e_iff, e_ids, e_idf, e_exs, e_wbf, e_vld;
        mw  = f_mem_wait();
        br  = hif.ex_branch_taken;
        lu  = f_load_use();
        e_vld = !reset && (hif.ex_mem_mem_read || hif.ex_mem_mem_write);
        e_ps  = !reset && (mw || (!br && lu));
        e_ifs = e_ps;
        e_red = !reset && !mw && br;
        e_iff = e_red;
        e_ids = !reset && mw;
        e_exs = e_ids;
        e_wbf = e_ids;
        e_idf = !reset && !mw && (br || lu);
        chk("m_dmem_valid",  hif.dmem_valid,   e_vld);
        chk("m_pc_stall",    hif.pc_stall,     e_ps);
        chk("m_pc_redirect", hif.pc_redirect,  e_red);
        chk("m_if_id_stall", hif.if_id_stall,  e_ifs);
        chk("m_if_id_flush", hif.if_id_flush,  e_iff);
        chk("m_id_ex_stall", hif.id_ex_stall,  e_ids);
        chk("m_id_ex_flush", hif.id_ex_flush,  e_idf);
        chk("m_ex_mem_stall", hif.ex_mem_stall, e_exs);
        chk("m_ex_mem_flush", hif.ex_mem_flush, 1'b0);
        chk("m_mem_wb_flush", hif.mem_wb_flush, e_wbf);
        chk("m_timeout_err", hif.mem_timeout_err, m_err);
        chk("m_stall_cnt",   hif.stall_cycle_cnt, m_cnt);
    end

    task automatic drive(input logic [4:0] rs1, input logic [4:0] rs2, input logic [4:0] rd,
                         input logic mr, input logic br, input logic ld, input logic st,
                         input logic rdy);
        hif.if_id_rs1        = rs1;
        hif.if_id_rs2        = rs2;
        hif.id_ex_rd         = rd;
        hif.id_ex_mem_read   = mr;
        hif.ex_branch_taken  = br;
        hif.ex_mem_mem_read  = ld;
        hif.ex_mem_mem_write = st;
        hif.dmem_ready       = rdy;
    endtask

    task automatic idle();
        drive(5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        int nv, ns;
        // Reset holds every output low even with a pending memory wait.
        drive(5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        #2;
        chk("rst_dmem_valid", hif.dmem_valid, 1'b0);
        chk("rst_pc_stall", hif.pc_stall, 1'b0);
        chk("rst_mem_wb_flush", hif.mem_wb_flush, 1'b0);
        tick(); tick();
        chk("rst_cnt", hif.stall_cycle_cnt, 32'd0);
        chk("rst_err", hif.mem_timeout_err, 1'b0);
        idle();
        reset = 1'b0;
        tick();

        // Load in MEM, ready low three cycles then high.
        nv = 0; ns = 0;
        for (int i = 0; i < 4; i++) begin
            drive(5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, (i == 3));
            #1;
            nv += int'(hif.dmem_valid);
            ns += int'(hif.pc_stall & hif.ex_mem_stall & hif.mem_wb_flush);
            tick();
        end
        idle();
        chk("t1_valid_cycles", nv, 4);
        chk("t1_stall_cycles", ns, 3);
        chk("t1_cnt", hif.stall_cycle_cnt, 32'd3);
        tick();

        // Load-use: lw x5 in EX, add x6,x5,x1 in ID.
        drive(5'd5, 5'd1, 5'd5, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        #1;
        chk("t2_pc_stall", hif.pc_stall, 1'b1);
        chk("t2_if_id_stall", hif.if_id_stall, 1'b1);
        chk("t2_id_ex_flush", hif.id_ex_flush, 1'b1);
        chk("t2_id_ex_stall", hif.id_ex_stall, 1'b0);
        tick();
        drive(5'd5, 5'd1, 5'd5, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        #1;
        chk("t2_bubble_done", hif.pc_stall, 1'b0);
        tick();
        drive(5'd2, 5'd5, 5'd5, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        #1;
        chk("t2_rs2_stall", hif.pc_stall, 1'b1);
        tick();
        drive(5'd0, 5'd0, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        #1;
        chk("t2_x0_stall", hif.pc_stall, 1'b0);
        chk("t2_x0_flush", hif.id_ex_flush, 1'b0);
        tick();
        chk("t2_cnt", hif.stall_cycle_cnt, 32'd5);

        // Branch beats load-use.
        drive(5'd5, 5'd1, 5'd5, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        #1;
        chk("t3_redirect", hif.pc_redirect, 1'b1);
        chk("t3_if_id_flush", hif.if_id_flush, 1'b1);
        chk("t3_id_ex_flush", hif.id_ex_flush, 1'b1);
        chk("t3_pc_stall", hif.pc_stall, 1'b0);
        chk("t3_if_id_stall", hif.if_id_stall, 1'b0);
        tick();

        // Branch held behind a memory wait.
        drive(5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
        #1;
        chk("t4_no_redirect", hif.pc_redirect, 1'b0);
        chk("t4_wb_flush", hif.mem_wb_flush, 1'b1);
        chk("t4_no_if_flush", hif.if_id_flush, 1'b0);
        tick(); tick();
        drive(5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1);
        #1;
        chk("t4_redirect", hif.pc_redirect, 1'b1);
        chk("t4_released", hif.pc_stall, 1'b0);
        tick();
        idle();
        tick();
        chk("t4_cnt", hif.stall_cycle_cnt, 32'd7);

        // Timeout: ready held low for 20 cycles.
        drive(5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        for (int i = 1; i <= 20; i++) begin
            tick();
            if (i == 16) chk("t5_err_before", hif.mem_timeout_err, 1'b0);
            if (i == 17) chk("t5_err_set", hif.mem_timeout_err, 1'b1);
        end
        drive(5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
        tick();
        chk("t5_err_sticky", hif.mem_timeout_err, 1'b1);
        idle();
        tick();
        chk("t5_err_sticky2", hif.mem_timeout_err, 1'b1);
        chk("t5_cnt", hif.stall_cycle_cnt, 32'd27);
        reset = 1'b1;
        #1;
        chk("t5_rst_err", hif.mem_timeout_err, 1'b0);
        chk("t5_rst_cnt", hif.stall_cycle_cnt, 32'd0);
        tick();
        reset = 1'b0;
        tick();

        // Reset asserted while waiting on memory.
        drive(5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        tick(); tick(); tick();
        chk("t6_waiting", hif.pc_stall, 1'b1);
        reset = 1'b1;
        #1;
        chk("t6_rst_stall", hif.pc_stall, 1'b0);
        chk("t6_rst_valid", hif.dmem_valid, 1'b0);
        chk("t6_rst_wbf", hif.mem_wb_flush, 1'b0);
        chk("t6_rst_cnt", hif.stall_cycle_cnt, 32'd0);
        tick();
        idle();
        reset = 1'b0;
        tick();
        chk("t6_cnt_after", hif.stall_cycle_cnt, 32'd0);
        chk("t6_err_after", hif.mem_timeout_err, 1'b0);
        drive(5'd7, 5'd0, 5'd7, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        tick();
        idle();
        chk("t6_cnt_resume", hif.stall_cycle_cnt, 32'd1);
        tick();

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule
